// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable data RAM: RV32I load/store
// funct3 codes, the controller state type and the access legality rule.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    // Unsigned variants exist only for loads; halves and words must be naturally aligned.
    function automatic logic accessLegal(input logic isStore,
                                         input logic [2:0] funct3,
                                         input logic [1:0] byteOff);
        logic legal;
        case (funct3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~byteOff[0];
            F3_W:    legal = (byteOff == 2'b00);
            F3_BU:   legal = ~isStore;
            F3_HU:   legal = ~isStore & ~byteOff[0];
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the byte/half/word selected by a load from a 32-bit memory word
// and sign- or zero-extends it to 32 bits.
module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byteSel_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        byteVal = word_i[8*byteSel_i +: 8];
        halfVal = byteSel_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byteVal[7]}}, byteVal};
            F3_H:    data_o = {{16{halfVal[15]}}, halfVal};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'h0, byteVal};
            F3_HU:   data_o = {16'h0, halfVal};
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// RV32I data memory: byte-lane stores, formatted registered loads with a
// VALID/ERROR strobe, and an optional post-reset clear sequencer.
module data_ram
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  REQ,
    input  logic                  WRITE_ENABLE,
    input  logic [2:0]            FUNCT3,
    input  logic [ADDR_WIDTH+1:0] ADDRESS,
    input  logic [31:0]           DATA_IN,
    output logic                  READY,
    output logic [31:0]           DATA_OUT,
    output logic                  VALID,
    output logic                  ERROR
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

    logic [31:0] mem_q [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clearCnt_q, clearCnt_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    logic [31:0]           dataOut_q, dataOut_d;

    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [1:0]            byteOff;
    logic                  accept;
    logic                  legal;
    logic [31:0]           rdWord;
    logic [31:0]           loadData;
    logic [3:0]            laneWe;
    logic [31:0]           storeData;

    assign wordIdx = ADDRESS[ADDR_WIDTH+1:2];
    assign byteOff = ADDRESS[1:0];
    assign accept  = REQ & ready_q;
    assign legal   = accessLegal(WRITE_ENABLE, FUNCT3, byteOff);
    assign rdWord  = mem_q[wordIdx];

    load_formatter u_loadFormatter (
        .word_i    (rdWord),
        .byteSel_i (byteOff),
        .funct3_i  (FUNCT3),
        .data_o    (loadData)
    );

    always_comb begin
        state_d    = state_q;
        clearCnt_d = clearCnt_q;
        case (state_q)
            ST_CLEAR: begin
                clearCnt_d = clearCnt_q + 1'b1;
                if (clearCnt_q == LAST_WORD) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: clearCnt_d = '0;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Stores replicate their data across all lanes so only the lane mask needs the offset.
    always_comb begin
        laneWe    = 4'b0000;
        storeData = DATA_IN;
        if (accept && WRITE_ENABLE && legal) begin
            case (FUNCT3[1:0])
                2'b00: begin
                    laneWe    = 4'b0001 << byteOff;
                    storeData = {4{DATA_IN[7:0]}};
                end
                2'b01: begin
                    laneWe    = byteOff[1] ? 4'b1100 : 4'b0011;
                    storeData = {2{DATA_IN[15:0]}};
                end
                default: laneWe = 4'b1111;
            endcase
        end
    end

    always_comb begin
        valid_d   = accept;
        error_d   = accept & ~legal;
        dataOut_d = dataOut_q;
        if (accept) begin
            if (!legal) begin
                dataOut_d = '0;
            end else if (!WRITE_ENABLE) begin
                dataOut_d = loadData;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            clearCnt_q <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
            dataOut_q  <= '0;
        end else begin
            state_q    <= state_d;
            clearCnt_q <= clearCnt_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
            dataOut_q  <= dataOut_d;
        end
    end

    // Storage has no reset; zeroing is done by the clear sequencer instead.
    always_ff @(posedge CLK) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clearCnt_q] <= '0;
        end else begin
            for (int lane = 0; lane < 4; lane++) begin
                if (laneWe[lane]) begin
                    mem_q[wordIdx][8*lane +: 8] <= storeData[8*lane +: 8];
                end
            end
        end
    end

    assign READY    = ready_q;
    assign VALID    = valid_q;
    assign ERROR    = error_q;
    assign DATA_OUT = dataOut_q;

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram (ADDR_WIDTH=4): directed vector table,
// clear/reset sequences, a back-to-back stream and randomized accesses.
module tb_data_ram;
    import mem_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        CLK;
    logic        RESET_N;
    logic        REQ;
    logic        WRITE_ENABLE;
    logic [2:0]  FUNCT3;
    logic [5:0]  ADDRESS;
    logic [31:0] DATA_IN;
    logic        READY;
    logic [31:0] DATA_OUT;
    logic        VALID;
    logic        ERROR;

    data_ram #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .REQ          (REQ),
        .WRITE_ENABLE (WRITE_ENABLE),
        .FUNCT3       (FUNCT3),
        .ADDRESS      (ADDRESS),
        .DATA_IN      (DATA_IN),
        .READY        (READY),
        .DATA_OUT     (DATA_OUT),
        .VALID        (VALID),
        .ERROR        (ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] refMem [DEPTH];
    logic [31:0] refOut;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [5:0]  addr;
        logic [31:0] din;
        logic [31:0] expData;
        logic        expErr;
    } vec_t;

    vec_t vecs [18];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, sample 1 ns later.
    task automatic applyStimulus(input logic req, input logic we, input logic [2:0] f3,
                                 input logic [5:0] addr, input logic [31:0] din);
        REQ          = req;
        WRITE_ENABLE = we;
        FUNCT3       = f3;
        ADDRESS      = addr;
        DATA_IN      = din;
        @(posedge CLK);
        #1;
    endtask

    // Reference model: RV32I access rules applied to a word array with plain arithmetic.
    task automatic modelAccess(input logic we, input logic [2:0] f3, input logic [5:0] addr,
                               input logic [31:0] din, output logic expErr);
        int          w;
        int          off;
        int          nBytes;
        logic        ok;
        logic [31:0] mask;
        logic [31:0] val;
        w      = int'(addr[5:2]);
        off    = int'(addr[1:0]);
        nBytes = 1 << f3[1:0];
        ok     = 1'b1;
        if (f3[1:0] == 2'b11) ok = 1'b0;
        if (we && f3[2]) ok = 1'b0;
        if (!we && f3 == 3'b110) ok = 1'b0;
        if (ok && (off % nBytes) != 0) ok = 1'b0;
        expErr = ~ok;
        if (!ok) begin
            refOut = 32'h0;
        end else if (we) begin
            for (int k = 0; k < nBytes; k++) begin
                refMem[w][8*(off+k) +: 8] = din[8*k +: 8];
            end
        end else begin
            mask = (nBytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nBytes)) - 32'h1);
            val  = (refMem[w] >> (8*off)) & mask;
            if (!f3[2] && nBytes < 4 && val[8*nBytes-1]) val = val | ~mask;
            refOut = val;
        end
    endtask

    // Counts edges after reset release until READY rises, watching for stray VALIDs.
    task automatic waitClear(input string tag);
        int   cycles;
        logic sawValid;
        cycles   = 0;
        sawValid = 1'b0;
        while (!READY && cycles < 200) begin
            @(posedge CLK);
            #1;
            cycles++;
            if (VALID) sawValid = 1'b1;
        end
        checkOutput({tag, "_ready_cycles"}, cycles, DEPTH);
        checkOutput({tag, "_no_valid"}, {31'h0, sawValid}, 32'h0);
        for (int i = 0; i < DEPTH; i++) refMem[i] = 32'h0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        expErr;
        logic [31:0] d;
        logic [5:0]  a;
        logic        req;
        logic        we;
        logic [2:0]  f3;
        int          validCount;

        vecs[0]  = '{1'b0, F3_W,   6'h3C, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, F3_W,   6'h08, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b0, F3_W,   6'h08, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, F3_B,   6'h0A, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b0, F3_B,   6'h0A, 32'h0000_0000, 32'hFFFF_FF80, 1'b0};
        vecs[5]  = '{1'b0, F3_BU,  6'h0A, 32'h0000_0000, 32'h0000_0080, 1'b0};
        vecs[6]  = '{1'b0, F3_H,   6'h0A, 32'h0000_0000, 32'hFFFF_DE80, 1'b0};
        vecs[7]  = '{1'b0, F3_HU,  6'h08, 32'h0000_0000, 32'h0000_BEEF, 1'b0};
        vecs[8]  = '{1'b0, F3_W,   6'h08, 32'h0000_0000, 32'hDE80_BEEF, 1'b0};
        vecs[9]  = '{1'b0, F3_W,   6'h0D, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b1, F3_W,   6'h0C, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b1, F3_H,   6'h0F, 32'h0000_1234, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, F3_W,   6'h0C, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{1'b0, 3'b011, 6'h00, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b1, F3_H,   6'h0E, 32'h0000_BBAA, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, F3_W,   6'h0C, 32'h0000_0000, 32'hBBAA_F00D, 1'b0};
        vecs[16] = '{1'b1, F3_BU,  6'h00, 32'h0000_0055, 32'h0000_0000, 1'b1};
        vecs[17] = '{1'b0, F3_B,   6'h0B, 32'h0000_0000, 32'hFFFF_FFDE, 1'b0};

        RESET_N      = 1'b0;
        REQ          = 1'b0;
        WRITE_ENABLE = 1'b0;
        FUNCT3       = 3'b000;
        ADDRESS      = 6'h00;
        DATA_IN      = 32'h0;
        refOut       = 32'h0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = 32'h0;

        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_ready", {31'h0, READY}, 32'h0);
        checkOutput("reset_valid", {31'h0, VALID}, 32'h0);
        checkOutput("reset_error", {31'h0, ERROR}, 32'h0);
        checkOutput("reset_data", DATA_OUT, 32'h0);

        // Hold a load request throughout the clear; it must be ignored.
        REQ          = 1'b1;
        WRITE_ENABLE = 1'b0;
        FUNCT3       = F3_W;
        ADDRESS      = 6'h00;
        RESET_N      = 1'b1;
        waitClear("clear");
        REQ = 1'b0;

        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].din);
            modelAccess(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].din, expErr);
            checkOutput($sformatf("vec%0d_valid", i), {31'h0, VALID}, 32'h1);
            checkOutput($sformatf("vec%0d_error", i), {31'h0, ERROR}, {31'h0, vecs[i].expErr});
            checkOutput($sformatf("vec%0d_data", i), DATA_OUT, vecs[i].expData);
        end
        applyStimulus(1'b0, 1'b0, F3_W, 6'h00, 32'h0);
        checkOutput("idle_valid", {31'h0, VALID}, 32'h0);
        checkOutput("idle_error", {31'h0, ERROR}, 32'h0);

        validCount = 0;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            a = (i % 2 == 0) ? 6'h14 : 6'h28;
            applyStimulus(1'b1, 1'b1, F3_W, a, d);
            modelAccess(1'b1, F3_W, a, d, expErr);
            if (VALID) validCount++;
            applyStimulus(1'b1, 1'b0, F3_W, a, 32'h0);
            modelAccess(1'b0, F3_W, a, 32'h0, expErr);
            if (VALID) validCount++;
            checkOutput($sformatf("stream%0d_data", i), DATA_OUT, d);
            checkOutput($sformatf("stream%0d_error", i), {31'h0, ERROR}, 32'h0);
        end
        checkOutput("stream_valid_count", validCount, 16);
        REQ = 1'b0;

        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(0, 3) != 0);
            we  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom);
            a   = 6'($urandom);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            d   = $urandom;
            applyStimulus(req, we, f3, a, d);
            expErr = 1'b0;
            if (req) modelAccess(we, f3, a, d, expErr);
            checkOutput($sformatf("rand%0d_valid", i), {31'h0, VALID}, {31'h0, req});
            checkOutput($sformatf("rand%0d_error", i), {31'h0, ERROR}, {31'h0, expErr});
            checkOutput($sformatf("rand%0d_data", i), DATA_OUT, refOut);
        end
        REQ = 1'b0;

        // Reset during an in-flight load result.
        applyStimulus(1'b1, 1'b1, F3_W, 6'h08, 32'hA5A5_5A5A);
        modelAccess(1'b1, F3_W, 6'h08, 32'hA5A5_5A5A, expErr);
        applyStimulus(1'b1, 1'b0, F3_W, 6'h08, 32'h0);
        REQ = 1'b0;
        checkOutput("pre_reset_valid", {31'h0, VALID}, 32'h1);
        checkOutput("pre_reset_data", DATA_OUT, 32'hA5A5_5A5A);
        RESET_N = 1'b0;
        #1;
        checkOutput("async_valid", {31'h0, VALID}, 32'h0);
        checkOutput("async_data", DATA_OUT, 32'h0);
        checkOutput("async_ready", {31'h0, READY}, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Interrupt the clear at cycle 5 and confirm it restarts from scratch.
        repeat (5) @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        checkOutput("midclear_ready", {31'h0, READY}, 32'h0);
        checkOutput("midclear_valid", {31'h0, VALID}, 32'h0);
        checkOutput("midclear_error", {31'h0, ERROR}, 32'h0);
        checkOutput("midclear_data", DATA_OUT, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        waitClear("reclear");
        refOut = 32'h0;

        applyStimulus(1'b1, 1'b0, F3_W, 6'h08, 32'h0);
        modelAccess(1'b0, F3_W, 6'h08, 32'h0, expErr);
        REQ = 1'b0;
        checkOutput("cleared_word_valid", {31'h0, VALID}, 32'h1);
        checkOutput("cleared_word_data", DATA_OUT, refOut);
        applyStimulus(1'b1, 1'b0, F3_W, 6'h14, 32'h0);
        REQ = 1'b0;
        checkOutput("cleared_word2_data", DATA_OUT, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
